// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_ctrl
//  Brief    : Instruction-fetch sequencer. Boots the PC, issues fetch
//             requests, applies trap/branch/jump redirects (queuing them while
//             a fetch is outstanding), holds a fetched instruction while decode
//             stalls, and raises a trap-vectored bus error on fetch timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
   parameter int              SIZE         = 32,
   parameter logic [SIZE-1:0] RESET_VECTOR = '0,
   parameter logic [SIZE-1:0] TRAP_VECTOR  = SIZE'(32'h0000_0100),
   parameter int              TIMEOUT      = 16
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic [SIZE-1:0] pc,
   input  logic            stall,
   input  logic            branch_taken,
   input  logic [SIZE-1:0] branch_target,
   input  logic            jump,
   input  logic [SIZE-1:0] jump_target,
   input  logic            trap,
   input  logic            imem_ack,
   output logic            imem_req,
   output logic [SIZE-1:0] imem_addr,
   output logic [SIZE-1:0] pc_in,
   output logic            pc_write,
   output logic            instr_valid,
   output logic            flush,
   output logic            bus_err
);

   // Counter only has to reach TIMEOUT-1; TIMEOUT is at least 2.
   localparam int              CW         = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0]   c_cnt_last = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0]   c_cnt_one  = CW'(1);
   localparam logic [SIZE-1:0] c_align    = ~SIZE'(3);
   localparam logic [SIZE-1:0] c_step     = SIZE'(4);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t          r_state;
   logic            r_pend_valid;
   logic [SIZE-1:0] r_pend_target;
   logic [CW-1:0]   r_count;

   state_t          w_state_nxt;
   logic            w_pend_valid_nxt;
   logic [SIZE-1:0] w_pend_target_nxt;
   logic [CW-1:0]   w_count_nxt;

   logic            w_redir;
   logic [SIZE-1:0] w_redir_target;
   logic [SIZE-1:0] w_pc_seq;
   logic            w_timeout;

   // Redirect selection: trap beats branch beats jump, targets word-aligned.
   always_comb begin
      w_redir = trap | branch_taken | jump;
      if (trap) begin
         w_redir_target = TRAP_VECTOR & c_align;
      end else if (branch_taken) begin
         w_redir_target = branch_target & c_align;
      end else begin
         w_redir_target = jump_target & c_align;
      end
      w_pc_seq  = pc + c_step;
      w_timeout = (r_count == c_cnt_last);
   end

   // Next-state and output decode; reset forces all outputs quiet.
   always_comb begin
      w_state_nxt       = r_state;
      w_pend_valid_nxt  = r_pend_valid;
      w_pend_target_nxt = r_pend_target;
      w_count_nxt       = r_count;
      imem_req          = 1'b0;
      imem_addr         = pc;
      pc_in             = w_pc_seq;
      pc_write          = 1'b0;
      instr_valid       = 1'b0;
      flush             = 1'b0;
      bus_err           = 1'b0;

      case (r_state)
         BOOT: begin
            pc_write         = 1'b1;
            pc_in            = RESET_VECTOR;
            w_pend_valid_nxt = 1'b0;
            w_count_nxt      = '0;
            w_state_nxt      = FETCH;
         end

         FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               // An ack always wins over a coincident timeout.
               w_count_nxt = '0;
               if (w_redir || r_pend_valid) begin
                  flush            = 1'b1;
                  pc_write         = 1'b1;
                  pc_in            = w_redir ? w_redir_target : r_pend_target;
                  w_pend_valid_nxt = 1'b0;
               end else if (!stall) begin
                  instr_valid = 1'b1;
                  pc_write    = 1'b1;
                  pc_in       = w_pc_seq;
               end else begin
                  instr_valid = 1'b1;
                  w_state_nxt = HOLD;
               end
            end else if (w_timeout) begin
               bus_err          = 1'b1;
               flush            = 1'b1;
               pc_write         = 1'b1;
               pc_in            = TRAP_VECTOR;
               w_pend_valid_nxt = 1'b0;
               w_count_nxt      = '0;
            end else begin
               // Fetch still outstanding: remember the latest redirect.
               w_count_nxt = r_count + c_cnt_one;
               if (w_redir) begin
                  w_pend_valid_nxt  = 1'b1;
                  w_pend_target_nxt = w_redir_target;
               end
            end
         end

         HOLD: begin
            w_count_nxt = '0;
            if (w_redir) begin
               flush            = 1'b1;
               pc_write         = 1'b1;
               pc_in            = w_redir_target;
               w_pend_valid_nxt = 1'b0;
               w_state_nxt      = FETCH;
            end else if (!stall) begin
               pc_write    = 1'b1;
               pc_in       = w_pc_seq;
               w_state_nxt = FETCH;
            end
         end

         default: begin
            w_state_nxt      = BOOT;
            w_pend_valid_nxt = 1'b0;
            w_count_nxt      = '0;
         end
      endcase

      if (RESET) begin
         imem_req    = 1'b0;
         pc_write    = 1'b0;
         instr_valid = 1'b0;
         flush       = 1'b0;
         bus_err     = 1'b0;
         pc_in       = RESET_VECTOR;
      end
   end

   // State, pending redirect and timeout counter registers.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state       <= BOOT;
         r_pend_valid  <= 1'b0;
         r_pend_target <= '0;
         r_count       <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_pend_valid  <= w_pend_valid_nxt;
         r_pend_target <= w_pend_target_nxt;
         r_count       <= w_count_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_ctrl
//  Brief    : Self-checking bench for fetch_ctrl (default parameters).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic [31:0] pc = '0;
   logic        stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = '0;
   logic        jump = 1'b0;
   logic [31:0] jump_target = '0;
   logic        trap = 1'b0;
   logic        imem_ack = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] pc_in;
   logic        pc_write;
   logic        instr_valid;
   logic        flush;
   logic        bus_err;

   int total = 0;
   int bad   = 0;

   fetch_ctrl dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .pc           (pc),
      .stall        (stall),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .jump         (jump),
      .jump_target  (jump_target),
      .trap         (trap),
      .imem_ack     (imem_ack),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .pc_in        (pc_in),
      .pc_write     (pc_write),
      .instr_valid  (instr_valid),
      .flush        (flush),
      .bus_err      (bus_err)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic        rst;
      logic [31:0] pc;
      logic        stall;
      logic        br;
      logic [31:0] bt;
      logic        jp;
      logic [31:0] jt;
      logic        tr;
      logic        ack;
   } stim_t;

   // Expected vector layout: {req, addr[31:0], wr, pc_in[31:0], iv, fl, be}.
   // pc_in is only meaningful when pinchk is set.
   typedef struct {
      string       nm;
      logic [68:0] v;
      bit          pinchk;
   } exp_t;

   exp_t sb[$];

   function automatic stim_t S(input logic rst, input logic [31:0] p, input logic st,
                               input logic br, input logic [31:0] bt, input logic jp,
                               input logic [31:0] jt, input logic tr, input logic ack);
      stim_t s;
      s.rst = rst; s.pc = p; s.stall = st; s.br = br; s.bt = bt;
      s.jp = jp; s.jt = jt; s.tr = tr; s.ack = ack;
      return s;
   endfunction

   function automatic exp_t E(input string nm, input logic req, input logic [31:0] addr,
                              input logic wr, input logic [31:0] pin, input logic iv,
                              input logic fl, input logic be, input bit chk);
      exp_t e;
      e.nm = nm;
      e.v = {req, addr, wr, pin, iv, fl, be};
      e.pinchk = chk;
      return e;
   endfunction

   task automatic drive(input stim_t s);
      RESET = s.rst; pc = s.pc; stall = s.stall;
      branch_taken = s.br; branch_target = s.bt;
      jump = s.jp; jump_target = s.jt;
      trap = s.tr; imem_ack = s.ack;
   endtask

   task automatic test_reset();
      stim_t st[$]; exp_t ex[$]; exp_t e; logic [68:0] obs;
      st.push_back(S(1, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(E("reset", 0, 0, 0, 0, 0, 0, 0, 1));
      st.push_back(S(1, 0, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(E("reset_ack", 0, 0, 0, 0, 0, 0, 0, 1));
      st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(E("boot", 0, 0, 1, 0, 0, 0, 0, 1));
      for (int i = 0; i < st.size(); i++) begin
         drive(st[i]); sb.push_back(ex[i]);
         @(negedge CLK); e = sb.pop_front();
         obs = {imem_req, imem_addr, pc_write, (e.pinchk ? pc_in : e.v[34:3]), instr_valid, flush, bus_err};
         total++;
         if (obs !== e.v) begin bad++; $display("FAIL %s[%0d] got=%h want=%h", e.nm, i, obs, e.v); end
         @(posedge CLK); #1;
      end
   endtask

   task automatic test_seq();
      stim_t st[$]; exp_t ex[$]; exp_t e; logic [68:0] obs;
      for (int k = 0; k < 3; k++) begin
         st.push_back(S(0, 32'(4 * k), 0, 0, 0, 0, 0, 0, 1));
         ex.push_back(E("seq", 1, 32'(4 * k), 1, 32'(4 * k + 4), 1, 0, 0, 1));
      end
      for (int i = 0; i < st.size(); i++) begin
         drive(st[i]); sb.push_back(ex[i]);
         @(negedge CLK); e = sb.pop_front();
         obs = {imem_req, imem_addr, pc_write, (e.pinchk ? pc_in : e.v[34:3]), instr_valid, flush, bus_err};
         total++;
         if (obs !== e.v) begin bad++; $display("FAIL %s[%0d] got=%h want=%h", e.nm, i, obs, e.v); end
         @(posedge CLK); #1;
      end
   endtask

   task automatic test_stall();
      stim_t st[$]; exp_t ex[$]; exp_t e; logic [68:0] obs;
      st.push_back(S(0, 32'h10, 1, 0, 0, 0, 0, 0, 1)); ex.push_back(E("stall_ack", 1, 32'h10, 0, 0, 1, 0, 0, 0));
      st.push_back(S(0, 32'h10, 1, 0, 0, 0, 0, 0, 0)); ex.push_back(E("hold", 0, 32'h10, 0, 0, 0, 0, 0, 0));
      st.push_back(S(0, 32'h10, 1, 0, 0, 0, 0, 0, 0)); ex.push_back(E("hold", 0, 32'h10, 0, 0, 0, 0, 0, 0));
      st.push_back(S(0, 32'h10, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(E("hold_release", 0, 32'h10, 1, 32'h14, 0, 0, 0, 1));
      st.push_back(S(0, 32'h14, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(E("after_hold", 1, 32'h14, 1, 32'h18, 1, 0, 0, 1));
      // Redirect while holding.
      st.push_back(S(0, 32'h18, 1, 0, 0, 0, 0, 0, 1)); ex.push_back(E("stall_ack2", 1, 32'h18, 0, 0, 1, 0, 0, 0));
      st.push_back(S(0, 32'h18, 1, 0, 0, 1, 32'h83, 0, 0)); ex.push_back(E("hold_jump", 0, 32'h18, 1, 32'h80, 0, 1, 0, 1));
      st.push_back(S(0, 32'h80, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(E("after_hold_jump", 1, 32'h80, 1, 32'h84, 1, 0, 0, 1));
      for (int i = 0; i < st.size(); i++) begin
         drive(st[i]); sb.push_back(ex[i]);
         @(negedge CLK); e = sb.pop_front();
         obs = {imem_req, imem_addr, pc_write, (e.pinchk ? pc_in : e.v[34:3]), instr_valid, flush, bus_err};
         total++;
         if (obs !== e.v) begin bad++; $display("FAIL %s[%0d] got=%h want=%h", e.nm, i, obs, e.v); end
         @(posedge CLK); #1;
      end
   endtask

   task automatic test_branch();
      stim_t st[$]; exp_t ex[$]; exp_t e; logic [68:0] obs;
      st.push_back(S(0, 32'h20, 0, 1, 32'h43, 0, 0, 0, 0)); ex.push_back(E("br_pend", 1, 32'h20, 0, 0, 0, 0, 0, 0));
      st.push_back(S(0, 32'h20, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(E("br_wait", 1, 32'h20, 0, 0, 0, 0, 0, 0));
      st.push_back(S(0, 32'h20, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(E("br_ack", 1, 32'h20, 1, 32'h40, 0, 1, 0, 1));
      // Later redirect overwrites the pending one.
      st.push_back(S(0, 32'h40, 0, 0, 0, 1, 32'h55, 0, 0)); ex.push_back(E("jp_pend", 1, 32'h40, 0, 0, 0, 0, 0, 0));
      st.push_back(S(0, 32'h40, 0, 1, 32'h66, 0, 0, 0, 0)); ex.push_back(E("br_over", 1, 32'h40, 0, 0, 0, 0, 0, 0));
      st.push_back(S(0, 32'h40, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(E("over_ack", 1, 32'h40, 1, 32'h64, 0, 1, 0, 1));
      st.push_back(S(0, 32'h64, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(E("pend_clear", 1, 32'h64, 1, 32'h68, 1, 0, 0, 1));
      for (int i = 0; i < st.size(); i++) begin
         drive(st[i]); sb.push_back(ex[i]);
         @(negedge CLK); e = sb.pop_front();
         obs = {imem_req, imem_addr, pc_write, (e.pinchk ? pc_in : e.v[34:3]), instr_valid, flush, bus_err};
         total++;
         if (obs !== e.v) begin bad++; $display("FAIL %s[%0d] got=%h want=%h", e.nm, i, obs, e.v); end
         @(posedge CLK); #1;
      end
   endtask

   task automatic test_priority();
      stim_t st[$]; exp_t ex[$]; exp_t e; logic [68:0] obs;
      st.push_back(S(0, 32'h68, 0, 1, 32'h200, 0, 0, 1, 1)); ex.push_back(E("trap_br", 1, 32'h68, 1, 32'h100, 0, 1, 0, 1));
      st.push_back(S(0, 32'h100, 0, 1, 32'h203, 1, 32'h300, 0, 1)); ex.push_back(E("br_jp", 1, 32'h100, 1, 32'h200, 0, 1, 0, 1));
      st.push_back(S(0, 32'h200, 0, 0, 0, 1, 32'h307, 0, 1)); ex.push_back(E("jp_only", 1, 32'h200, 1, 32'h304, 0, 1, 0, 1));
      // Current redirect beats a pending one at ack.
      st.push_back(S(0, 32'h304, 0, 0, 0, 1, 32'h400, 0, 0)); ex.push_back(E("jp_pend2", 1, 32'h304, 0, 0, 0, 0, 0, 0));
      st.push_back(S(0, 32'h304, 0, 0, 0, 0, 0, 1, 1)); ex.push_back(E("trap_vs_pend", 1, 32'h304, 1, 32'h100, 0, 1, 0, 1));
      for (int i = 0; i < st.size(); i++) begin
         drive(st[i]); sb.push_back(ex[i]);
         @(negedge CLK); e = sb.pop_front();
         obs = {imem_req, imem_addr, pc_write, (e.pinchk ? pc_in : e.v[34:3]), instr_valid, flush, bus_err};
         total++;
         if (obs !== e.v) begin bad++; $display("FAIL %s[%0d] got=%h want=%h", e.nm, i, obs, e.v); end
         @(posedge CLK); #1;
      end
   endtask

   task automatic test_timeout();
      stim_t st[$]; exp_t ex[$]; exp_t e; logic [68:0] obs;
      // 15 silent cycles (one carrying a branch), then timeout on the 16th.
      for (int k = 0; k < 15; k++) begin
         st.push_back(S(0, 32'h80, 0, (k == 2), 32'h40, 0, 0, 0, 0));
         ex.push_back(E("tmo_wait", 1, 32'h80, 0, 0, 0, 0, 0, 0));
      end
      st.push_back(S(0, 32'h80, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(E("tmo_fire", 1, 32'h80, 1, 32'h100, 0, 1, 1, 1));
      // Ack on the 16th cycle wins; pending from before the timeout is gone.
      for (int k = 0; k < 15; k++) begin
         st.push_back(S(0, 32'h100, 0, 0, 0, 0, 0, 0, 0));
         ex.push_back(E("tmo_wait2", 1, 32'h100, 0, 0, 0, 0, 0, 0));
      end
      st.push_back(S(0, 32'h100, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(E("tmo_ack_wins", 1, 32'h100, 1, 32'h104, 1, 0, 0, 1));
      for (int i = 0; i < st.size(); i++) begin
         drive(st[i]); sb.push_back(ex[i]);
         @(negedge CLK); e = sb.pop_front();
         obs = {imem_req, imem_addr, pc_write, (e.pinchk ? pc_in : e.v[34:3]), instr_valid, flush, bus_err};
         total++;
         if (obs !== e.v) begin bad++; $display("FAIL %s[%0d] got=%h want=%h", e.nm, i, obs, e.v); end
         @(posedge CLK); #1;
      end
   endtask

   task automatic test_wrap_and_reset();
      stim_t st[$]; exp_t ex[$]; exp_t e; logic [68:0] obs;
      st.push_back(S(0, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(E("wrap", 1, 32'hFFFF_FFFC, 1, 32'h0, 1, 0, 0, 1));
      // Reset mid-fetch with a pending branch and a running counter.
      st.push_back(S(0, 32'h10, 0, 1, 32'h50, 0, 0, 0, 0)); ex.push_back(E("pre_rst", 1, 32'h10, 0, 0, 0, 0, 0, 0));
      st.push_back(S(1, 32'h10, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(E("mid_rst", 0, 32'h10, 0, 0, 0, 0, 0, 1));
      st.push_back(S(0, 32'h10, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(E("reboot", 0, 32'h10, 1, 0, 0, 0, 0, 1));
      st.push_back(S(0, 32'h0, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(E("post_rst", 1, 32'h0, 1, 32'h4, 1, 0, 0, 1));
      // Reset while in HOLD.
      st.push_back(S(0, 32'h4, 1, 0, 0, 0, 0, 0, 1)); ex.push_back(E("to_hold", 1, 32'h4, 0, 0, 1, 0, 0, 0));
      st.push_back(S(1, 32'h4, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(E("hold_rst", 0, 32'h4, 0, 0, 0, 0, 0, 1));
      st.push_back(S(0, 32'h4, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(E("reboot2", 0, 32'h4, 1, 0, 0, 0, 0, 1));
      for (int i = 0; i < st.size(); i++) begin
         drive(st[i]); sb.push_back(ex[i]);
         @(negedge CLK); e = sb.pop_front();
         obs = {imem_req, imem_addr, pc_write, (e.pinchk ? pc_in : e.v[34:3]), instr_valid, flush, bus_err};
         total++;
         if (obs !== e.v) begin bad++; $display("FAIL %s[%0d] got=%h want=%h", e.nm, i, obs, e.v); end
         @(posedge CLK); #1;
      end
   endtask

   initial begin
      test_reset();
      test_seq();
      test_stall();
      test_branch();
      test_priority();
      test_timeout();
      test_wrap_and_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
